// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one completed result per
// accepted cycle and broadcasts it through a registered valid/ready stage.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SRC_W-1:0]            cdb_src,
  input  logic                        cdb_ready,
  input  logic                        flush,
  output logic                        cdb_idle
);

  logic [SRC_W-1:0]  ptr_reg;
  logic [SRC_W-1:0]  ptr_next;
  logic [SRC_W-1:0]  sel;
  logic              any_req;
  logic              can_accept;
  logic              grant;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic              valid_next;
  logic [TAG_W-1:0]  tag_next;
  logic [DATA_W-1:0] data_next;
  logic [SRC_W-1:0]  src_next;

  assign any_req    = |req;
  assign can_accept = !cdb_valid || cdb_ready;
  // reset_n gates the grant so ack is low for the whole time reset is held,
  // not just after the registers have cleared.
  assign grant      = reset_n && can_accept && !flush && any_req;
  assign cdb_idle   = !cdb_valid && !any_req;

  // Cyclic scan starting at the priority pointer; first requesting index wins.
  always_comb begin
    int idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        sel   = SRC_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign sel_tag  = req_tag[sel*TAG_W +: TAG_W];
  assign sel_data = req_data[sel*DATA_W +: DATA_W];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = grant && (sel == SRC_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_next   = ptr_reg;
    valid_next = cdb_valid;
    tag_next   = cdb_tag;
    data_next  = cdb_data;
    src_next   = cdb_src;
    if (flush) begin
      // Squash only the valid bit; payload and pointer are left as they were.
      valid_next = 1'b0;
    end else if (grant) begin
      valid_next = 1'b1;
      tag_next   = sel_tag;
      data_next  = sel_data;
      src_next   = sel;
      ptr_next   = (sel == SRC_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end else if (cdb_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg   <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      cdb_valid <= valid_next;
      cdb_tag   <= tag_next;
      cdb_data  <= data_next;
      cdb_src   <= src_next;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a table of per-cycle vectors plus
// hand-written reset sequences.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  ack;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic        cdb_ready;
  logic        flush;
  logic        cdb_idle;

  int tests_run;
  int tests_failed;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(4), .DATA_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .ack       (ack),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .cdb_ready (cdb_ready),
    .flush     (flush),
    .cdb_idle  (cdb_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] req;
    logic       rdy;
    logic       fl;
    logic [3:0] exp_ack;
    logic       exp_idle;
    logic       exp_valid;
    logic [1:0] exp_src;
  } vec_t;

  vec_t tbl [17];

  // Requester i always presents tag 4+i and data 0x0123 + i*0x1111.
  function automatic logic [3:0] tag_of(input int i);
    return 4'(4 + i);
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return 32'h0000_0123 + 32'(i) * 32'h0000_1111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*4 +: 4]   = tag_of(i);
      req_data[i*32 +: 32] = data_of(i);
    end

    //            req     rdy   fl    ack     idle  valid src
    tbl[0]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1};  // single requester
    tbl[1]  = '{4'b1011, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3};  // ptr=2 skips 0,1
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};  // fairness
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3};
    tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};  // wrap 3->0
    tbl[7]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};  // backpressure
    tbl[8]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[10] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2};  // release, ptr->3
    tbl[11] = '{4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2};  // flush, payload held
    tbl[12] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3};  // ptr still 3
    tbl[13] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3};  // flush with valid=1
    tbl[14] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};  // granted after flush
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};  // drain
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0};  // idle

    // Reset state, with ack forced low even while requests are present.
    reset_n   = 1'b0;
    req       = 4'b0000;
    cdb_ready = 1'b1;
    flush     = 1'b0;
    #2;
    chk("reset_valid", 32'(cdb_valid), 32'd0);
    chk("reset_tag",   32'(cdb_tag),   32'd0);
    chk("reset_data",  cdb_data,       32'd0);
    chk("reset_src",   32'(cdb_src),   32'd0);
    chk("reset_idle",  32'(cdb_idle),  32'd1);
    req = 4'b1111;
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    @(posedge clock); #1;
    chk("reset_hold_valid", 32'(cdb_valid), 32'd0);
    reset_n = 1'b1;
    req     = 4'b0000;
    #1;
    chk("idle_no_req", 32'(cdb_idle), 32'd1);

    for (int r = 0; r < 17; r++) begin
      req       = tbl[r].req;
      cdb_ready = tbl[r].rdy;
      flush     = tbl[r].fl;
      #1;
      chk($sformatf("row%0d_ack", r),    32'(ack),         32'(tbl[r].exp_ack));
      chk($sformatf("row%0d_onehot", r), 32'($onehot0(ack)), 32'd1);
      chk($sformatf("row%0d_idle", r),   32'(cdb_idle),    32'(tbl[r].exp_idle));
      @(posedge clock); #1;
      chk($sformatf("row%0d_valid", r), 32'(cdb_valid), 32'(tbl[r].exp_valid));
      chk($sformatf("row%0d_src", r),   32'(cdb_src),   32'(tbl[r].exp_src));
      chk($sformatf("row%0d_tag", r),   32'(cdb_tag),   32'(tag_of(int'(tbl[r].exp_src))));
      chk($sformatf("row%0d_data", r),  cdb_data,       data_of(int'(tbl[r].exp_src)));
      $display("[TB] row %0d req=%b rdy=%0d flush=%0d ack=%b valid=%0d src=%0d",
               r, tbl[r].req, tbl[r].rdy, tbl[r].fl, ack, cdb_valid, cdb_src);
    end

    // Reset mid-broadcast: ptr is 1 here; grant requester 2 so ptr becomes 3.
    req       = 4'b0100;
    cdb_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clock); #1;
    chk("mid_pre_valid", 32'(cdb_valid), 32'd1);
    chk("mid_pre_src",   32'(cdb_src),   32'd2);
    #1;
    chk("mid_pre_ack", 32'(ack), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(cdb_valid), 32'd0);
    chk("mid_async_ack",   32'(ack),       32'd0);
    chk("mid_async_src",   32'(cdb_src),   32'd0);
    chk("mid_async_tag",   32'(cdb_tag),   32'd0);
    req       = 4'b1010;
    cdb_ready = 1'b1;
    #1;
    chk("mid_held_ack", 32'(ack), 32'd0);
    @(posedge clock); #1;
    chk("mid_held_valid", 32'(cdb_valid), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("post_reset_ack", 32'(ack), 32'b0010);
    @(posedge clock); #1;
    chk("post_reset_valid", 32'(cdb_valid), 32'd1);
    chk("post_reset_src",   32'(cdb_src),   32'd1);
    chk("post_reset_tag",   32'(cdb_tag),   32'd5);
    chk("post_reset_data",  cdb_data,       32'h0000_1234);
    $display("[TB] reset sequence ack=%b valid=%0d src=%0d", ack, cdb_valid, cdb_src);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) between the out-of-order core's result producers: add unit, load unit, branch (bne) unit and store unit. Each producer holds a completed result (ROB tag plus value) until granted. The arbiter broadcasts exactly one result per accepted cycle through a registered output stage with valid/ready backpressure toward the ROB and reservation stations. A flush input, raised on branch mispredict at the same moment the PC controller receives its redirect, discards the pending broadcast.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; index 0=add, 1=lw, 2=bne, 3=sw
- TAG_W, 4, ROB tag width
- DATA_W, 32, result width

Ports:
- clock  input  1  single clock, all state updates on posedge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  requester i holds a valid result
- req_tag  input  NUM_REQ*TAG_W  tag of requester i in bits [i*TAG_W +: TAG_W]
- req_data  input  NUM_REQ*DATA_W  value of requester i in bits [i*DATA_W +: DATA_W]
- ack  output  NUM_REQ  one-hot, combinational; requester i's result is taken at this edge
- cdb_valid  output  1  broadcast register holds a result
- cdb_tag  output  TAG_W  broadcast tag
- cdb_data  output  DATA_W  broadcast value
- cdb_src  output  clog2(NUM_REQ)  index of the producer of the current broadcast
- cdb_ready  input  1  consumers accept the broadcast this cycle
- flush  input  1  synchronous squash of the broadcast and suppression of grants
- cdb_idle  output  1  !cdb_valid && (req == 0); feeds the issue-stall logic

## Operation
- State: priority pointer ptr (clog2(NUM_REQ) bits); output registers cdb_valid, cdb_tag, cdb_data, cdb_src.
- can_accept = !cdb_valid || cdb_ready.
- Selection: sel is the first index i, scanning ptr, ptr+1, … cyclically modulo NUM_REQ, for which req[i]=1.
- ack[sel] = can_accept && !flush && |req. All other ack bits are 0. At most one ack bit is high at any time.
- Posedge, evaluated in priority order:
  - flush=1: cdb_valid<=0. No ack. ptr unchanged. tag, data and src are held.
  - Else, if an ack is issued: cdb_valid<=1; cdb_tag, cdb_data and cdb_src load from requester sel; ptr<=(sel+1) mod NUM_REQ. Wrap: sel=NUM_REQ-1 gives ptr=0.
  - Else, if cdb_ready: cdb_valid<=0.
  - Else: hold all state.
- Requester contract:
  - req, tag and data stay stable until ack is seen high at a posedge.
  - The requester may drop req, or present the next result, in the cycle after ack.
  - The arbiter never acks a requester whose req is 0.
- Back-to-back: with cdb_valid=1 and cdb_ready=1, a new grant loads at the same edge. This sustains 1 broadcast per cycle.
- Reset (reset_n=0, asynchronous): ptr=0; cdb_valid=0; cdb_tag=0; cdb_data=0; cdb_src=0. Consequently ack=0. A reset mid-broadcast drops the held result with no ack replay.

## Timing
- Latency from req to cdb_valid: 1 cycle when the bus is free and the requester wins. ack is seen in cycle N; cdb_valid is high in cycle N+1.
- Worst-case wait with all requesters active and cdb_ready=1: NUM_REQ-1 grants.
- cdb_* outputs are purely registered. ack and cdb_idle are combinational from req, state, cdb_ready and flush.
- Under backpressure, cdb_valid, cdb_tag, cdb_data and cdb_src are stable while cdb_valid=1 and cdb_ready=0.
- Flush and ack in the same cycle: flush wins and ack stays 0. The requester retains its result; squashing the requester is the requester's responsibility.
- Reset release: the first grant can occur at the first posedge after reset_n rises.

## Test plan
- Single requester: reset, then req=4'b0010, tag=5, data=0x1234, cdb_ready=1.
  - Required: ack=4'b0010 in cycle 0.
  - Required: cycle 1 shows cdb_valid=1, tag=5, data=0x1234, src=1, ptr=2.
- Fairness and wrap: req=4'b1111 held, cdb_ready=1.
  - Required: grants in order src 0,1,2,3,0 on consecutive cycles, ptr wrapping 3→0.
  - Required: ack is always one-hot.
- Backpressure: cdb_valid=1 with cdb_ready=0 for 3 cycles, req=4'b0100.
  - Required: ack=0 and cdb_* frozen for those cycles.
  - Required: on cdb_ready=1, ack[2] fires the same cycle and the new result appears next cycle.
- Flush: cdb_valid=1 and req=4'b0001 with flush=1 for one cycle.
  - Required: ack=0 that cycle; cdb_valid=0 next cycle; ptr unchanged.
  - Required: requester 0 is granted the cycle after flush drops.
- Reset mid-operation: assert reset_n=0 mid-cycle while cdb_valid=1 and ptr=3.
  - Required: cdb_valid=0, ptr=0 and ack=0 immediately, without waiting for a clock edge.
  - Required: after release with req=4'b1010, the first grant goes to src 1.
- Idle flag: with no req and cdb_valid=0, cdb_idle=1.
  - Required: cdb_idle falls in the same cycle req rises.
